// File: rtl/rv32_handshake_core.sv
// rv32_handshake_core: multi-cycle RV32I/RV32E core with req/ready instruction and data ports.
// One instruction in flight: FETCH -> EXECUTE -> (MEM) -> FETCH; HALT absorbs EBREAK and trapped faults.
module rv32_handshake_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] imemAddr,
    output logic        imemReq,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] dmemAddr,
    output logic        dmemRReq,
    output logic [3:0]  dmemWMask,
    output logic [31:0] dmemWData,
    input  logic        dmemReady,
    input  logic [31:0] dmemRData,
    output logic        retire,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [1:0]  dbgState
);
    // Handshakes: a request (imemReq, dmemRReq, nonzero dmemWMask) is held with stable address/data
    // until the matching ready is sampled high on a rising edge; that edge completes the transfer.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        MEM     = 2'd2,
        HALT    = 2'd3
    } stateT;

    localparam int IDXW = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    stateT       state;
    stateT       nextState;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] instr;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immB;
    logic [31:0] immU;
    logic [31:0] immJ;

    logic        legal;
    logic        usesRs1;
    logic        usesRs2;
    logic        usesRd;
    logic        isEbreak;
    logic        isLoad;
    logic        isStore;
    logic        illegal;
    logic        regFault;

    logic [31:0] aluB;
    logic [4:0]  shamt;
    logic [31:0] aluOut;
    logic        brTaken;
    logic        takenJump;
    logic [31:0] jumpTarget;
    logic        jumpMisaligned;
    logic [31:0] memAddr;
    logic        memMisaligned;
    logic        fault;
    logic [1:0]  faultCause;
    logic [31:0] pcPlus4;
    logic [31:0] execResult;

    logic [31:0] storeData;
    logic [3:0]  storeMask;
    logic [31:0] loadShift;
    logic [31:0] loadData;

    logic        wbEn;
    logic [31:0] wbData;
    logic        setHalt;
    logic        setTrap;
    logic [1:0]  causeNext;

    function automatic logic [31:0] readReg(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx[IDXW-1:0]];
    endfunction

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign immI   = {{20{instr[31]}}, instr[31:20]};
    assign immS   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU   = {instr[31:12], 12'd0};
    assign immJ   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        legal    = 1'b0;
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        usesRd   = 1'b0;
        isEbreak = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                legal  = 1'b1;
                usesRd = 1'b1;
            end
            OP_JALR: begin
                legal   = (f3 == 3'b000);
                usesRd  = 1'b1;
                usesRs1 = 1'b1;
            end
            OP_BRANCH: begin
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
            end
            OP_LOAD: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                          (f3 == 3'b100) || (f3 == 3'b101);
                usesRd  = 1'b1;
                usesRs1 = 1'b1;
            end
            OP_STORE: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
            end
            OP_IMM: begin
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
                usesRd  = 1'b1;
                usesRs1 = 1'b1;
            end
            OP_REG: begin
                legal   = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                usesRd  = 1'b1;
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
            end
            OP_FENCE: legal = (f3 == 3'b000);
            OP_SYSTEM: begin
                // funct3=0 is ECALL/EBREAK only; CSR forms are accepted and executed as NOPs
                if (f3 == 3'b000) begin
                    legal    = (instr[31:21] == 11'd0) && (instr[19:7] == 13'd0);
                    isEbreak = legal && instr[20];
                end else begin
                    legal = (f3 != 3'b100);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign isLoad   = (opcode == OP_LOAD);
    assign isStore  = (opcode == OP_STORE);
    assign regFault = (NUM_REGS == 16) &&
                      ((usesRd && rd[4]) || (usesRs1 && rs1[4]) || (usesRs2 && rs2[4]));
    assign illegal  = !legal || regFault;

    assign aluB  = (opcode == OP_REG) ? rs2Val : immI;
    assign shamt = aluB[4:0];

    always_comb begin
        aluOut = 32'd0;
        case (f3)
            3'b000:  aluOut = ((opcode == OP_REG) && f7[5]) ? rs1Val - aluB : rs1Val + aluB;
            3'b001:  aluOut = rs1Val << shamt;
            3'b010:  aluOut = {31'd0, $signed(rs1Val) < $signed(aluB)};
            3'b011:  aluOut = {31'd0, rs1Val < aluB};
            3'b100:  aluOut = rs1Val ^ aluB;
            3'b101:  aluOut = f7[5] ? 32'($signed(rs1Val) >>> shamt) : rs1Val >> shamt;
            3'b110:  aluOut = rs1Val | aluB;
            default: aluOut = rs1Val & aluB;
        endcase
    end

    always_comb begin
        brTaken = 1'b0;
        case (f3)
            3'b000:  brTaken = (rs1Val == rs2Val);
            3'b001:  brTaken = (rs1Val != rs2Val);
            3'b100:  brTaken = $signed(rs1Val) < $signed(rs2Val);
            3'b101:  brTaken = $signed(rs1Val) >= $signed(rs2Val);
            3'b110:  brTaken = rs1Val < rs2Val;
            3'b111:  brTaken = rs1Val >= rs2Val;
            default: brTaken = 1'b0;
        endcase
    end

    assign pcPlus4 = pc + 32'd4;

    always_comb begin
        jumpTarget = pc + immB;
        if (opcode == OP_JAL)       jumpTarget = pc + immJ;
        else if (opcode == OP_JALR) jumpTarget = (rs1Val + immI) & ~32'd1;
    end

    assign takenJump      = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                            ((opcode == OP_BRANCH) && brTaken);
    assign jumpMisaligned = takenJump && jumpTarget[1];

    assign memAddr       = rs1Val + (isStore ? immS : immI);
    assign memMisaligned = ((f3[1:0] == 2'b01) && memAddr[0]) ||
                           ((f3[1:0] == 2'b10) && (memAddr[1:0] != 2'b00));

    assign fault      = illegal || ((isLoad || isStore) && memMisaligned) || jumpMisaligned;
    assign faultCause = illegal ? 2'd1 : (((isLoad || isStore) && memMisaligned) ? 2'd2 : 2'd3);

    always_comb begin
        case (opcode)
            OP_LUI:           execResult = immU;
            OP_AUIPC:         execResult = pc + immU;
            OP_JAL, OP_JALR:  execResult = pcPlus4;
            default:          execResult = aluOut;
        endcase
    end

    always_comb begin
        case (f3[1:0])
            2'b00: begin
                storeData = {4{rs2Val[7:0]}};
                storeMask = 4'b0001 << memAddr[1:0];
            end
            2'b01: begin
                storeData = {2{rs2Val[15:0]}};
                storeMask = memAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = rs2Val;
                storeMask = 4'b1111;
            end
        endcase
    end

    assign loadShift = dmemRData >> {memAddr[1:0], 3'b000};

    always_comb begin
        case (f3)
            3'b000:  loadData = {{24{loadShift[7]}}, loadShift[7:0]};
            3'b001:  loadData = {{16{loadShift[15]}}, loadShift[15:0]};
            3'b100:  loadData = {24'd0, loadShift[7:0]};
            3'b101:  loadData = {16'd0, loadShift[15:0]};
            default: loadData = loadShift;
        endcase
    end

    always_comb begin
        nextState = state;
        pcNext    = pc;
        retire    = 1'b0;
        wbEn      = 1'b0;
        wbData    = 32'd0;
        setHalt   = 1'b0;
        setTrap   = 1'b0;
        causeNext = trapCause;
        case (state)
            FETCH: begin
                if (imemReady) nextState = EXECUTE;
            end
            EXECUTE: begin
                if (isEbreak) begin
                    nextState = HALT;
                    setHalt   = 1'b1;
                    causeNext = 2'd0;
                end else if (fault) begin
                    if (TRAP_EN) begin
                        nextState = HALT;
                        setHalt   = 1'b1;
                        setTrap   = 1'b1;
                        causeNext = faultCause;
                    end else begin
                        nextState = FETCH;
                        pcNext    = pcPlus4;
                        retire    = 1'b1;
                    end
                end else if (isLoad || isStore) begin
                    nextState = MEM;
                end else begin
                    nextState = FETCH;
                    pcNext    = takenJump ? jumpTarget : pcPlus4;
                    retire    = 1'b1;
                    wbEn      = usesRd;
                    wbData    = execResult;
                end
            end
            MEM: begin
                if (dmemReady) begin
                    nextState = FETCH;
                    pcNext    = pcPlus4;
                    retire    = 1'b1;
                    wbEn      = isLoad;
                    wbData    = loadData;
                end
            end
            default: begin
                nextState = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            instr     <= 32'd0;
            rs1Val    <= 32'd0;
            rs2Val    <= 32'd0;
            halted    <= 1'b0;
            trap      <= 1'b0;
            trapCause <= 2'd0;
        end else begin
            state <= nextState;
            pc    <= pcNext;
            if (state == FETCH && imemReady) begin
                instr  <= imemData;
                rs1Val <= readReg(imemData[19:15]);
                rs2Val <= readReg(imemData[24:20]);
            end
            if (setHalt) begin
                halted    <= 1'b1;
                trapCause <= causeNext;
            end
            if (setTrap) trap <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wbEn && (rd != 5'd0)) regs[rd[IDXW-1:0]] <= wbData;
    end

    // imemReq is gated by resetn so a fetch request drops the instant reset asserts
    assign imemAddr  = pc;
    assign imemReq   = resetn && (state == FETCH);
    assign dmemAddr  = (state == MEM) ? memAddr : 32'd0;
    assign dmemRReq  = (state == MEM) && isLoad;
    assign dmemWMask = ((state == MEM) && isStore) ? storeMask : 4'd0;
    assign dmemWData = ((state == MEM) && isStore) ? storeData : 32'd0;
    assign dbgState  = state;

endmodule

// File: tb/tb_rv32_handshake_core.sv
// Directed bench for rv32_handshake_core: three instances cover default, TRAP_EN=0 with RESET_PC=0x100,
// and NUM_REGS=16; the bench plays both memories and checks handshakes, writeback (via stores) and traps.
module tb_rv32_handshake_core;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        resetn    [ND];
    logic [31:0] imemAddr  [ND];
    logic        imemReq   [ND];
    logic        imemReady [ND];
    logic [31:0] imemData  [ND];
    logic [31:0] dmemAddr  [ND];
    logic        dmemRReq  [ND];
    logic [3:0]  dmemWMask [ND];
    logic [31:0] dmemWData [ND];
    logic        dmemReady [ND];
    logic [31:0] dmemRData [ND];
    logic        retire    [ND];
    logic        halted    [ND];
    logic        trap      [ND];
    logic [1:0]  trapCause [ND];
    logic [1:0]  dbgState  [ND];

    int nCmp = 0;
    int nErr = 0;
    logic [31:0] expQ[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    for (genvar g = 0; g < ND; g++) begin : gDut
        rv32_handshake_core #(
            .RESET_PC ((g == 1) ? 32'h0000_0100 : 32'h0000_0000),
            .NUM_REGS ((g == 2) ? 16 : 32),
            .TRAP_EN  ((g == 1) ? 1'b0 : 1'b1)
        ) dut (
            .clk       (clk),
            .resetn    (resetn[g]),
            .imemAddr  (imemAddr[g]),
            .imemReq   (imemReq[g]),
            .imemReady (imemReady[g]),
            .imemData  (imemData[g]),
            .dmemAddr  (dmemAddr[g]),
            .dmemRReq  (dmemRReq[g]),
            .dmemWMask (dmemWMask[g]),
            .dmemWData (dmemWData[g]),
            .dmemReady (dmemReady[g]),
            .dmemRData (dmemRData[g]),
            .retire    (retire[g]),
            .halted    (halted[g]),
            .trap      (trap[g]),
            .trapCause (trapCause[g]),
            .dbgState  (dbgState[g])
        );
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // instruction encoders
    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic cycle();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic doReset(input int d, input logic [31:0] expPc);
        resetn[d] = 1'b0;
        #1;
        checkVal("rstImemAddr", imemAddr[d], expPc);
        checkVal("rstImemReq", {31'd0, imemReq[d]}, 0);
        checkVal("rstDmem", {26'd0, dmemRReq[d], dmemWMask[d], retire[d]}, 0);
        checkVal("rstDmemAddrData", dmemAddr[d] | dmemWData[d], 0);
        checkVal("rstStatus", {28'd0, halted[d], trap[d], trapCause[d]}, 0);
        imemReady[d] = 1'b1;
        dmemReady[d] = 1'b1;
        cycle();
        checkVal("rstHoldQuiet", {27'd0, dmemRReq[d], dmemWMask[d]} | {31'd0, retire[d]}, 0);
        imemReady[d] = 1'b0;
        dmemReady[d] = 1'b0;
        resetn[d]    = 1'b1;
        #1;
    endtask

    task automatic fetch(input int d, input logic [31:0] ins, input logic [31:0] expPc,
                         input int waits);
        checkVal("fetchReq", {31'd0, imemReq[d]}, 1);
        checkVal("fetchPc", imemAddr[d], expPc);
        checkVal("fetchNoRetire", {31'd0, retire[d]}, 0);
        for (int i = 0; i < waits; i++) begin
            cycle();
            checkVal("fetchHold", {imemAddr[d][30:0], imemReq[d]}, {expPc[30:0], 1'b1});
        end
        imemReady[d] = 1'b1;
        imemData[d]  = ins;
        cycle();
        imemReady[d] = 1'b0;
        imemData[d]  = 32'd0;
    endtask

    task automatic aluOp(input int d, input logic [31:0] ins, input logic [31:0] pc, input int waits);
        fetch(d, ins, pc, waits);
        checkVal("execRetire", {31'd0, retire[d]}, 1);
        checkVal("execNoMem", {27'd0, dmemRReq[d], dmemWMask[d]}, 0);
        cycle();
    endtask

    task automatic memOp(input int d, input logic [31:0] ins, input logic [31:0] pc,
                         input bit isStore, input logic [31:0] expAddr, input logic [3:0] expMask,
                         input logic [31:0] rdata, input int waits);
        logic [31:0] expData;
        int reqCycles;
        reqCycles = 0;
        expData   = 32'd0;
        fetch(d, ins, pc, 0);
        checkVal("memExecNoRetire", {31'd0, retire[d]}, 0);
        checkVal("memExecNoReq", {27'd0, dmemRReq[d], dmemWMask[d]}, 0);
        cycle();
        if (isStore) expData = expQ.pop_front();
        for (int i = 0; i <= waits; i++) begin
            if (dmemRReq[d]) reqCycles++;
            checkVal("memAddr", dmemAddr[d], expAddr);
            checkVal("memMask", {28'd0, dmemWMask[d]}, {28'd0, expMask});
            checkVal("memRReq", {31'd0, dmemRReq[d]}, {31'd0, !isStore});
            if (isStore) checkVal("memWData", dmemWData[d], expData);
            if (i < waits) begin
                checkVal("memWaitNoRetire", {31'd0, retire[d]}, 0);
                cycle();
            end
        end
        dmemReady[d] = 1'b1;
        dmemRData[d] = rdata;
        #1;
        checkVal("memRetire", {31'd0, retire[d]}, 1);
        cycle();
        dmemReady[d] = 1'b0;
        dmemRData[d] = 32'd0;
        if (!isStore) checkVal("loadReqCycles", reqCycles, waits + 1);
    endtask

    task automatic haltCheck(input int d, input bit expTrap, input logic [1:0] expCause,
                             input logic [31:0] expPc);
        checkVal("haltFlags", {29'd0, halted[d], trap[d], 1'b0}, {29'd0, 1'b1, expTrap, 1'b0});
        checkVal("haltCause", {30'd0, trapCause[d]}, {30'd0, expCause});
        checkVal("haltPc", imemAddr[d], expPc);
        checkVal("haltState", {30'd0, dbgState[d]}, 32'd3);
        imemReady[d] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkVal("haltQuiet", {26'd0, imemReq[d], dmemRReq[d], dmemWMask[d]} | {31'd0, retire[d]}, 0);
            cycle();
        end
        imemReady[d] = 1'b0;
        checkVal("haltSticky", {31'd0, halted[d]}, 1);
        checkVal("haltPcHeld", imemAddr[d], expPc);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            resetn[d]    = 1'b0;
            imemReady[d] = 1'b0;
            imemData[d]  = 32'd0;
            dmemReady[d] = 1'b0;
            dmemRData[d] = 32'd0;
        end
        cycle();

        // default core: ALU chain, waited load, byte load, stores of every width
        doReset(0, 32'h0);
        aluOp(0, encI(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0, 0);
        aluOp(0, encI(12'hFF9, 5'd1, 3'b000, 5'd2, 7'b0010011), 32'h4, 0);
        expQ.push_back(32'hFFFF_FFFE);
        memOp(0, encS(12'd0, 5'd2, 5'd0, 3'b010), 32'h8, 1'b1, 32'h0, 4'b1111, 32'h0, 0);
        memOp(0, encI(12'd4, 5'd0, 3'b010, 5'd3, 7'b0000011), 32'hC, 1'b0, 32'h4, 4'b0000,
              32'h8000_00F0, 3);
        memOp(0, encI(12'd7, 5'd0, 3'b000, 5'd4, 7'b0000011), 32'h10, 1'b0, 32'h7, 4'b0000,
              32'h8011_2233, 0);
        expQ.push_back(32'h8000_00F0);
        memOp(0, encS(12'd0, 5'd3, 5'd0, 3'b010), 32'h14, 1'b1, 32'h0, 4'b1111, 32'h0, 0);
        expQ.push_back(32'hFFFF_FF80);
        memOp(0, encS(12'd0, 5'd4, 5'd0, 3'b010), 32'h18, 1'b1, 32'h0, 4'b1111, 32'h0, 1);
        aluOp(0, {20'h12345, 5'd5, 7'b0110111}, 32'h1C, 2);
        aluOp(0, encI(12'h678, 5'd5, 3'b000, 5'd5, 7'b0010011), 32'h20, 0);
        expQ.push_back(32'h7878_7878);
        memOp(0, encS(12'd3, 5'd5, 5'd0, 3'b000), 32'h24, 1'b1, 32'h3, 4'b1000, 32'h0, 0);
        expQ.push_back(32'h5678_5678);
        memOp(0, encS(12'd2, 5'd5, 5'd0, 3'b001), 32'h28, 1'b1, 32'h2, 4'b1100, 32'h0, 0);

        // reset lands in the middle of a stalled SW
        fetch(0, encS(12'd8, 5'd5, 5'd0, 3'b010), 32'h2C, 0);
        cycle();
        cycle();
        checkVal("stallSwMask", {28'd0, dmemWMask[0]}, 32'hF);
        checkVal("stallSwAddr", dmemAddr[0], 32'h8);
        doReset(0, 32'h0);

        // taken BEQ to pc+6: target bit1 set
        fetch(0, encB(13'd6, 5'd0, 5'd0, 3'b000), 32'h0, 0);
        checkVal("beqExecNoRetire", {31'd0, retire[0]}, 0);
        cycle();
        haltCheck(0, 1'b1, 2'd3, 32'h0);

        // TRAP_EN=0 core, reset vector 0x100: faults become NOPs
        doReset(1, 32'h100);
        aluOp(1, encI(12'd9, 5'd0, 3'b000, 5'd3, 7'b0010011), 32'h100, 0);
        aluOp(1, encI(12'h102, 5'd0, 3'b010, 5'd3, 7'b0000011), 32'h104, 0);
        expQ.push_back(32'h9);
        memOp(1, encS(12'd0, 5'd3, 5'd0, 3'b010), 32'h108, 1'b1, 32'h0, 4'b1111, 32'h0, 0);
        aluOp(1, 32'hFFFF_FFFF, 32'h10C, 0);
        aluOp(1, encI(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h110, 0);
        expQ.push_back(32'h0);
        memOp(1, encS(12'd0, 5'd0, 5'd0, 3'b010), 32'h114, 1'b1, 32'h0, 4'b1111, 32'h0, 0);
        aluOp(1, encJ(21'd8, 5'd1), 32'h118, 0);
        expQ.push_back(32'h11C);
        memOp(1, encS(12'd0, 5'd1, 5'd0, 3'b010), 32'h120, 1'b1, 32'h0, 4'b1111, 32'h0, 0);
        checkVal("noTrapNoHalt", {30'd0, halted[1], trap[1]}, 0);

        // NUM_REGS=16 core: misaligned LW, out-of-range register, EBREAK
        doReset(2, 32'h0);
        fetch(2, encI(12'h102, 5'd0, 3'b010, 5'd3, 7'b0000011), 32'h0, 0);
        checkVal("lwMisExec", {30'd0, retire[2], dmemRReq[2]}, 0);
        cycle();
        haltCheck(2, 1'b1, 2'd2, 32'h0);

        doReset(2, 32'h0);
        aluOp(2, encI(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h0, 0);
        fetch(2, {7'd0, 5'd2, 5'd1, 3'b000, 5'd17, 7'b0110011}, 32'h4, 0);
        checkVal("addX17Exec", {31'd0, retire[2]}, 0);
        cycle();
        haltCheck(2, 1'b1, 2'd1, 32'h4);

        doReset(2, 32'h0);
        fetch(2, 32'h0010_0073, 32'h0, 0);
        checkVal("ebreakExec", {31'd0, retire[2]}, 0);
        cycle();
        haltCheck(2, 1'b0, 2'd0, 32'h0);

        checkVal("expQDrained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
